// File: rtl/crank_wheel_gen_pkg.sv
// Shared types and helpers for the crank wheel generator.
// Widths, FSM state encoding, latched configuration record and validity/clamp helpers.
package crank_gen_pkg;

    localparam int WIDTH_PER     = 24;
    localparam int WIDTH_TOOTH   = 8;
    localparam int MIN_TOOTH_PER = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACT   = 2'd1,
        ST_INACT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [WIDTH_PER-1:0]   per;
        logic [WIDTH_PER-1:0]   duty;
        logic [WIDTH_TOOTH-1:0] total;
        logic [WIDTH_TOOTH-1:0] gap;
        logic                   pol;
    } cfg_t;

    function automatic logic cfg_invalid(
        input logic [WIDTH_PER-1:0]   per,
        input logic [WIDTH_TOOTH-1:0] total,
        input logic [WIDTH_TOOTH-1:0] gap
    );
        return (per < WIDTH_PER'(MIN_TOOTH_PER)) || (gap >= total) || (total == '0);
    endfunction

    // Duty is clamped so every tooth keeps at least one inactive tick.
    function automatic cfg_t cfg_latch(
        input logic [WIDTH_PER-1:0]   per,
        input logic [WIDTH_PER-1:0]   duty,
        input logic [WIDTH_TOOTH-1:0] total,
        input logic [WIDTH_TOOTH-1:0] gap,
        input logic                   pol
    );
        cfg_t c;
        c.per   = per;
        c.duty  = (duty >= per) ? (per - WIDTH_PER'(1)) : duty;
        c.total = total;
        c.gap   = gap;
        c.pol   = pol;
        return c;
    endfunction

endpackage

// File: rtl/crank_wheel_gen_tooth_timer.sv
// Per-tooth tick counter: counts ena ticks from 0 to per-1 and flags the
// duty boundary and the tooth end on the tick that reaches them.
module tooth_timer
    import crank_gen_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ena,
    input  logic                 i_clr,
    input  logic [WIDTH_PER-1:0] i_duty,
    input  logic [WIDTH_PER-1:0] i_per,
    output logic                 o_duty_hit,
    output logic                 o_tooth_end
);

    logic [WIDTH_PER-1:0] r_cnt;
    logic [WIDTH_PER-1:0] w_cnt_inc;

    assign w_cnt_inc   = r_cnt + WIDTH_PER'(1);
    assign o_duty_hit  = i_ena && (w_cnt_inc == i_duty);
    assign o_tooth_end = i_ena && (r_cnt == (i_per - WIDTH_PER'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_ena) begin
            r_cnt <= o_tooth_end ? '0 : w_cnt_inc;
        end
    end

endmodule

// File: rtl/crank_wheel_gen.sv
// Missing-tooth crank wheel generator; config latched at start and at each revolution wrap.
// Optional CRANK_GEN_CAM_EN adds a cam output toggling once per revolution.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | stopped, q holds inactive level of last pol
// ST_ACT   | real tooth, active level
// ST_INACT | real tooth, inactive level
// ST_GAP   | missing-tooth region, inactive level
module crank_wheel_gen
    import crank_gen_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_ena,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [WIDTH_PER-1:0]   i_tooth_per,
    input  logic [WIDTH_PER-1:0]   i_duty,
    input  logic [WIDTH_TOOTH-1:0] i_teeth_total,
    input  logic [WIDTH_TOOTH-1:0] i_teeth_gap,
    input  logic                   i_pol,
    output logic                   o_q,
    output logic [WIDTH_TOOTH-1:0] o_tooth_num,
    output logic                   o_gap,
    output logic                   o_rev_strb,
    output logic                   o_busy,
    output logic                   o_cfg_err,
    output logic                   o_cam
);

    state_t                 r_state, w_state_nxt;
    cfg_t                   r_cfg, w_cfg_nxt, w_cfg_new;
    logic [WIDTH_TOOTH-1:0] r_tooth_num, w_tooth_nxt, w_next_idx, w_real_teeth;
    logic                   r_stop_pend, w_stop_now, w_wrap, w_cfg_err;
    logic                   w_duty_hit, w_tooth_end, w_run, w_last;
    logic                   r_q, r_gap, r_rev_strb, r_busy;
    logic                   w_q_nxt, w_gap_nxt, w_busy_nxt;

    assign w_cfg_err    = cfg_invalid(i_tooth_per, i_teeth_total, i_teeth_gap);
    assign w_cfg_new    = cfg_latch(i_tooth_per, i_duty, i_teeth_total, i_teeth_gap, i_pol);
    assign w_run        = (r_state != ST_IDLE);
    assign w_stop_now   = r_stop_pend | i_stop;
    assign w_next_idx   = r_tooth_num + WIDTH_TOOTH'(1);
    assign w_real_teeth = r_cfg.total - r_cfg.gap;
    assign w_last       = (w_next_idx == r_cfg.total);

    tooth_timer u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ena      (i_ena & w_run),
        .i_clr      (~w_run),
        .i_duty     (r_cfg.duty),
        .i_per      (r_cfg.per),
        .o_duty_hit (w_duty_hit),
        .o_tooth_end(w_tooth_end)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_nxt   = r_cfg;
        w_tooth_nxt = r_tooth_num;
        w_wrap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !w_cfg_err) begin
                    w_cfg_nxt   = w_cfg_new;
                    w_tooth_nxt = '0;
                    w_state_nxt = (w_cfg_new.duty == '0) ? ST_INACT : ST_ACT;
                end
            end
            default: begin
                if (w_tooth_end) begin
                    if (w_last) begin
                        // Revolution boundary: the only point a new config may take effect.
                        w_wrap      = 1'b1;
                        w_tooth_nxt = '0;
                        if (!w_cfg_err) begin
                            w_cfg_nxt = w_cfg_new;
                        end
                        if (w_stop_now) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = (w_cfg_nxt.duty == '0) ? ST_INACT : ST_ACT;
                        end
                    end else begin
                        w_tooth_nxt = w_next_idx;
                        if (w_next_idx >= w_real_teeth) begin
                            w_state_nxt = ST_GAP;
                        end else begin
                            w_state_nxt = (r_cfg.duty == '0) ? ST_INACT : ST_ACT;
                        end
                    end
                end else if ((r_state == ST_ACT) && w_duty_hit) begin
                    w_state_nxt = ST_INACT;
                end
            end
        endcase
    end

    always_comb begin
        w_q_nxt    = (w_state_nxt == ST_ACT) ^ w_cfg_nxt.pol;
        w_gap_nxt  = (w_state_nxt == ST_GAP);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cfg       <= '0;
            r_tooth_num <= '0;
            r_stop_pend <= 1'b0;
            r_q         <= 1'b0;
            r_gap       <= 1'b0;
            r_rev_strb  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cfg       <= w_cfg_nxt;
            r_tooth_num <= w_tooth_nxt;
            r_stop_pend <= (w_state_nxt == ST_IDLE) ? 1'b0 : (r_stop_pend | (w_run & i_stop));
            r_q         <= w_q_nxt;
            r_gap       <= w_gap_nxt;
            r_rev_strb  <= w_wrap;
            r_busy      <= w_busy_nxt;
        end
    end

`ifdef CRANK_GEN_CAM_EN
    logic r_cam;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cam <= 1'b0;
        end else if (w_state_nxt == ST_IDLE) begin
            r_cam <= 1'b0;
        end else if (w_wrap) begin
            r_cam <= ~r_cam;
        end
    end

    assign o_cam = r_cam;
`else
    assign o_cam = 1'b0;
`endif

    assign o_q         = r_q;
    assign o_tooth_num = r_tooth_num;
    assign o_gap       = r_gap;
    assign o_rev_strb  = r_rev_strb;
    assign o_busy      = r_busy;
    assign o_cfg_err   = w_cfg_err;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Scoreboard bench for crank_wheel_gen: stimulus queues per-cycle expectations,
// a negedge monitor compares every entry due in the current cycle.
`timescale 1ns/1ps
module tb_crank_wheel_gen;
    import crank_gen_pkg::*;

    localparam int SIG_Q = 0, SIG_TN = 1, SIG_GAP = 2, SIG_REV = 3, SIG_BUSY = 4, SIG_ERR = 5, SIG_CAM = 6;
`ifdef CRANK_GEN_CAM_EN
    localparam bit CAM = 1'b1;
`else
    localparam bit CAM = 1'b0;
`endif

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ena_div = 1;
    int   s;

    logic                   clk = 1'b0, rst_n = 1'b1, ena = 1'b1, start = 1'b0, stop = 1'b0, pol = 1'b0;
    logic [WIDTH_PER-1:0]   tooth_per = 24'd4, duty = 24'd2;
    logic [WIDTH_TOOTH-1:0] teeth_total = 8'd6, teeth_gap = 8'd2;
    logic                   q, gap_o, rev_strb, busy, cfg_err, cam;
    logic [WIDTH_TOOTH-1:0] tooth_num;
    logic [31:0]            act;

    crank_wheel_gen dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ena        (ena),
        .i_start      (start),
        .i_stop       (stop),
        .i_tooth_per  (tooth_per),
        .i_duty       (duty),
        .i_teeth_total(teeth_total),
        .i_teeth_gap  (teeth_gap),
        .i_pol        (pol),
        .o_q          (q),
        .o_tooth_num  (tooth_num),
        .o_gap        (gap_o),
        .o_rev_strb   (rev_strb),
        .o_busy       (busy),
        .o_cfg_err    (cfg_err),
        .o_cam        (cam)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sig);
        logic [31:0] a;
        case (sig)
            SIG_Q:    a = {31'b0, q};
            SIG_TN:   a = {24'b0, tooth_num};
            SIG_GAP:  a = {31'b0, gap_o};
            SIG_REV:  a = {31'b0, rev_strb};
            SIG_BUSY: a = {31'b0, busy};
            SIG_ERR:  a = {31'b0, cfg_err};
            SIG_CAM:  a = {31'b0, cam};
            default:  a = '1;
        endcase
        return a;
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                act = actual(sb[i].sig);
                checks++;
                if ((sb[i].cyc < cyc) || (act !== 32'(sb[i].val))) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %0h want %0h", sb[i].name, sb[i].cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ena = (ena_div <= 1) ? 1'b1 : ((cyc % ena_div) == 0);
    endtask

    task automatic run_to(input int c);
        int guard = 0;
        while (cyc < c && guard < 2000) begin
            step();
            guard++;
        end
    endtask

    task automatic push(input int c, input int sig, input int val, input string nm);
        exp_t e;
        e.cyc  = c;
        e.sig  = sig;
        e.val  = val;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle_chk(input int c, input bit p, input bit rv);
        push(c, SIG_Q, p, "idle_q");
        push(c, SIG_TN, 0, "idle_tooth_num");
        push(c, SIG_GAP, 0, "idle_gap");
        push(c, SIG_REV, rv, "idle_rev_strb");
        push(c, SIG_BUSY, 0, "idle_busy");
        push(c, SIG_CAM, 0, "idle_cam");
    endtask

    task automatic zero_chk(input int c, input string nm);
        push(c, SIG_Q, 0, {nm, "_q"});
        push(c, SIG_TN, 0, {nm, "_tooth_num"});
        push(c, SIG_GAP, 0, {nm, "_gap"});
        push(c, SIG_REV, 0, {nm, "_rev_strb"});
        push(c, SIG_BUSY, 0, {nm, "_busy"});
        push(c, SIG_CAM, 0, {nm, "_cam"});
    endtask

    // Reference wheel: a tooth is active while its tick index is below duty_l.
    task automatic wave(input int st, input int n, input int per, input int dl, input int total,
                        input int gn, input bit p, input bit rev0, input int cam0);
        int cnt, tooth, revs;
        bit rv, actv, en;
        cnt = 0; tooth = 0; revs = cam0; rv = rev0;
        for (int c = st; c < st + n; c++) begin
            actv = (tooth < total - gn) && (cnt < dl);
            push(c, SIG_Q, actv ^ p, "wave_q");
            push(c, SIG_TN, tooth, "wave_tooth_num");
            push(c, SIG_GAP, (tooth >= total - gn), "wave_gap");
            push(c, SIG_REV, rv, "wave_rev_strb");
            push(c, SIG_BUSY, 1, "wave_busy");
            push(c, SIG_CAM, CAM ? (revs % 2) : 0, "wave_cam");
            rv = 1'b0;
            en = (ena_div <= 1) ? 1'b1 : ((c % ena_div) == 0);
            if (en) begin
                cnt++;
                if (cnt == per) begin
                    cnt = 0;
                    tooth++;
                    if (tooth == total) begin
                        tooth = 0;
                        rv = 1'b1;
                        revs++;
                    end
                end
            end
        end
    endtask

    task automatic do_start(output int st);
        start = 1'b1;
        step();
        start = 1'b0;
        st = cyc;
    endtask

    task automatic err_chk(input int per, input int total, input int gn, input bit exp_err, input string nm);
        tooth_per   = WIDTH_PER'(per);
        teeth_total = WIDTH_TOOTH'(total);
        teeth_gap   = WIDTH_TOOTH'(gn);
        start       = exp_err;
        push(cyc, SIG_ERR, exp_err, nm);
        push(cyc + 1, SIG_BUSY, 0, {nm, "_busy"});
        step();
        start = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        step();
        zero_chk(cyc, "reset");
        step();
        rst_n = 1'b1;
        step();

        // 6-2 wheel, active-high, stop requested in tooth 2 of the second revolution
        tooth_per = 24'd4; duty = 24'd2; teeth_total = 8'd6; teeth_gap = 8'd2; pol = 1'b0;
        do_start(s);
        wave(s, 48, 4, 2, 6, 2, 1'b0, 1'b0, 0);
        run_to(s + 32);
        stop = 1'b1;
        step();
        stop = 1'b0;
        idle_chk(s + 48, 1'b0, 1'b1);
        idle_chk(s + 49, 1'b0, 1'b0);
        run_to(s + 50);

        // same wheel, active-low; idle keeps inactive-high level until reset
        pol = 1'b1;
        do_start(s);
        wave(s, 24, 4, 2, 6, 2, 1'b1, 1'b0, 0);
        run_to(s + 3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        idle_chk(s + 24, 1'b1, 1'b1);
        idle_chk(s + 26, 1'b1, 1'b0);
        run_to(s + 27);
        rst_n = 1'b0;
        push(cyc, SIG_Q, 0, "rst_idle_q");
        push(cyc, SIG_BUSY, 0, "rst_idle_busy");
        step();
        rst_n = 1'b1;
        pol = 1'b0;
        step();

        // prescaled: ena every third clock, reset lands mid-revolution
        ena_div = 3;
        tooth_per = 24'd3; duty = 24'd1; teeth_total = 8'd4; teeth_gap = 8'd1;
        do_start(s);
        wave(s, 40, 3, 1, 4, 1, 1'b0, 1'b0, 0);
        run_to(s + 40);
        rst_n = 1'b0;
        zero_chk(cyc, "rst_mid");
        step();
        rst_n = 1'b1;
        ena_div = 1;
        step();

        // duty clamp, no gap teeth, period change applied only at wrap
        tooth_per = 24'd4; duty = 24'd10; teeth_total = 8'd3; teeth_gap = 8'd0;
        do_start(s);
        wave(s, 12, 4, 3, 3, 0, 1'b0, 1'b0, 0);
        run_to(s + 5);
        tooth_per = 24'd2;
        wave(s + 12, 6, 2, 1, 3, 0, 1'b0, 1'b1, 1);
        run_to(s + 13);
        stop = 1'b1;
        step();
        stop = 1'b0;
        idle_chk(s + 18, 1'b0, 1'b1);
        run_to(s + 20);

        // configuration validity and ignored requests in idle
        err_chk(1, 6, 2, 1'b1, "err_per1");
        err_chk(4, 6, 6, 1'b1, "err_gap_eq_total");
        err_chk(4, 0, 0, 1'b1, "err_total0");
        err_chk(2, 6, 5, 1'b0, "err_ok_edge");
        stop = 1'b1;
        push(cyc + 1, SIG_BUSY, 0, "stop_in_idle");
        step();
        stop = 1'b0;
        step();
        step();

        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crank_wheel_gen.md
# crank_wheel_gen

Programmable tooth-wheel signal generator that emits a missing-tooth crank pattern (e.g. 60-2), the transmit-side counterpart of the capture/filter/edge-detect chain. It drives a bench or loopback input of the capture path with a deterministic tooth train, timed in prescaler ticks, so that angle generation can be exercised without a real sensor. Configuration is latched at start and at every revolution boundary, so on-the-fly changes never produce a torn tooth.

## Interface
- WIDTH_PER, 24, width of tooth period / duty tick counters
- WIDTH_TOOTH, 8, width of tooth count fields
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ena  in  1  prescaler tick strobe; all timing advances only on clk edges with ena=1
- start  in  1  start request pulse (level-sampled each clk)
- stop  in  1  graceful stop request (level-sampled each clk)
- tooth_per  in  WIDTH_PER  tooth period in ticks
- duty  in  WIDTH_PER  active-level ticks per tooth
- teeth_total  in  WIDTH_TOOTH  teeth per revolution, gaps included (60)
- teeth_gap  in  WIDTH_TOOTH  missing teeth at end of revolution (2)
- pol  in  1  0: active-high teeth, 1: active-low teeth
- q  out  1  generated wheel signal
- tooth_num  out  WIDTH_TOOTH  current tooth index, 0..teeth_total-1
- gap  out  1  high while in missing-tooth region
- rev_strb  out  1  one-clk pulse at revolution wrap
- busy  out  1  high in any state except IDLE
- cfg_err  out  1  combinational: current inputs invalid
- cam  out  1  phase output (see Configuration)

## Operation
- States: IDLE, ACT (active level), INACT (inactive level in real tooth), GAP (missing teeth).
- Internal level lvl (1 = tooth active); q = lvl ^ pol_l, pol_l latched.
- cfg_err = (tooth_per < 2) | (teeth_gap >= teeth_total) | (teeth_total == 0).
- IDLE: start=1 and cfg_err=0 -> latch tooth_per, duty, teeth_total, teeth_gap, pol; tick cnt=0, tooth_num=0, state ACT (INACT if duty_l==0). start with cfg_err=1 ignored. stop ignored in IDLE.
- duty_l clamped to tooth_per_l-1 at latch (at least one inactive tick per tooth).
- On each ena: cnt+1. ACT -> INACT when cnt reaches duty_l. Tooth ends when cnt reaches tooth_per_l-1: cnt=0, tooth_num+1.
- Next tooth index >= teeth_total-teeth_gap -> GAP (lvl=0, gap=1) for whole teeth, counted identically.
- End of tooth teeth_total-1: tooth_num=0, rev_strb pulse, relatch config (only if new cfg_err=0; otherwise keep old), enter ACT; if stop pending -> IDLE instead.
- stop while busy sets stop_pend; cleared on IDLE entry. start while busy ignored.
- teeth_gap=0: no GAP state ever entered; gap stays 0.

## Timing
- Reset values: q=0, tooth_num=0, gap=0, rev_strb=0, busy=0, cam=0; state IDLE, pol_l=0.
- start sampled at edge N -> q active, busy=1 after edge N; first ena counted at edge N+1 or later.
- Active phase lasts exactly duty_l ena-ticks; tooth lasts exactly tooth_per_l ena-ticks; revolution = teeth_total*tooth_per_l ticks.
- All outputs registered except cfg_err.
- Reset asserted mid-revolution: immediate IDLE, all outputs to reset values.
- ena=0 freezes all counters and outputs.

## Configuration
- CRANK_GEN_CAM_EN defined: cam toggles at every rev_strb (one period per two revolutions, 720° phase); cleared on IDLE entry.
- Undefined: cam tied to 0, no toggle register.

## Structure
- Package crank_gen_pkg: state enum typedef, cfg struct typedef (per, duty, total, gap, pol), MIN_TOOTH_PER=2 constant.
- One sub-module tooth_timer: tick counter with ena, clear, duty/period compare, emitting duty_hit and tooth_end.

## Test plan
- ena=1 always, tooth_per=4, duty=2, total=6, gap=2, pol=0, start -> q 1,1,0,0 ×4 teeth then 8 cycles 0; rev_strb every 24 clks; gap high for last 8.
- Same with pol=1 -> q inverted, q=1 in IDLE after first start latch; reset restores q=0.
- ena every 3rd clk, tooth_per=3, duty=1 -> each tooth spans 9 clks, active 3 clks.
- duty=10, tooth_per=4 -> active 3 ticks, inactive 1; tooth_per=1 or gap=6,total=6 -> cfg_err=1, start ignored, busy=0.
- stop at tooth 2 -> generation continues to wrap, rev_strb then busy=0 next clk; change tooth_per mid-revolution -> applies only after rev_strb.
- CRANK_GEN_CAM_EN: cam toggles on each rev_strb; rst low mid-tooth -> all outputs 0 immediately.
